// File: rtl/rx_fifo_pkg.sv
// Shared UART parameters: receiver byte width and RX FIFO depth live here so both sides agree.
package rx_fifo_pkg;

    localparam int UART_DATA_SIZE  = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    // Per-cycle pointer operation, encoded as {push, pop}
    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'b00,
        FIFO_POP      = 2'b01,
        FIFO_PUSH     = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer: show-ahead read port,
// registered occupancy count and a sticky overflow flag for dropped bytes.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DATA_SIZE  = UART_DATA_SIZE,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_SIZE-1:0]  din,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [DATA_SIZE-1:0]  dout,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  push, pop, drop;
    fifo_op_e              op;

    // A read in the same cycle frees the slot, so a full FIFO still accepts a write alongside it
    assign push = wr && (!full || rd);
    assign pop  = rd && !empty;
    assign drop = wr && full && !rd;
    assign op   = fifo_op(push, pop);

    always_comb begin
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        case (op)
            FIFO_PUSH: begin
                wr_ptr_next = wr_ptr + PTR_ONE;
                count_next  = count_reg + COUNT_ONE;
            end
            FIFO_POP: begin
                rd_ptr_next = rd_ptr + PTR_ONE;
                count_next  = count_reg - COUNT_ONE;
            end
            FIFO_PUSH_POP: begin
                wr_ptr_next = wr_ptr + PTR_ONE;
                rd_ptr_next = rd_ptr + PTR_ONE;
            end
            default: begin
            end
        endcase

        // A dropped byte outranks a clear request arriving in the same cycle
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is never cleared; reset only discards it by rewinding the pointers
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout     = mem[rd_ptr];
    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == COUNT_MAX);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic          clr_ovf;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf   = 1'b0;
    logic          model_valid = 1'b0;
    int            wr_bias;

    rx_fifo #(.DATA_SIZE(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .din      (din),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one edge worth of inputs, then return to idle just after the edge
    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                 input logic c, input logic rs);
        @(negedge clk);
        wr = w; din = d; rd = r; clr_ovf = c; rst = rs;
        @(posedge clk);
        #1;
        wr = 1'b0; din = '0; rd = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
    endtask

    // Reference model: a byte queue plus a sticky flag, advanced once per rising edge
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (wr && model_q.size() == DEPTH && !rd) begin
                model_ovf = 1'b1;
            end else if (clr_ovf) begin
                model_ovf = 1'b0;
            end
            if (rd && model_q.size() > 0) begin
                void'(model_q.pop_front());
            end
            if (wr && model_q.size() < DEPTH) begin
                model_q.push_back(din);
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("cmp_count", 32'(count), 32'(model_q.size()));
            checkOutput("cmp_empty", 32'(empty), 32'(model_q.size() == 0));
            checkOutput("cmp_full", 32'(full), 32'(model_q.size() == DEPTH));
            checkOutput("cmp_overflow", 32'(overflow), 32'(model_ovf));
            if (model_q.size() > 0) begin
                checkOutput("cmp_dout", 32'(dout), 32'(model_q[0]));
            end
        end
    end

    initial begin
        wr = 1'b0; din = '0; rd = 1'b0; clr_ovf = 1'b0; rst = 1'b0;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);

        // Ordering with show-ahead output
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        checkOutput("order_first_visible", 32'(dout), 32'h41);
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        checkOutput("order_dout0", 32'(dout), 32'h41);
        checkOutput("order_count3", 32'(count), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("order_dout1", 32'(dout), 32'h42);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("order_dout2", 32'(dout), 32'h43);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("order_empty", 32'(empty), 32'd1);

        // Fill, then a dropped write
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        checkOutput("fill_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_overflow", 32'(overflow), 32'd1);
        checkOutput("drop_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_dout", 32'(dout), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_overflow", 32'(overflow), 32'd0);

        // Simultaneous write and read while full, then while empty
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("both_full_count", 32'(count), 32'd16);
        checkOutput("both_full_ovf", 32'(overflow), 32'd0);
        checkOutput("both_full_head", 32'(dout), 32'h11);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("both_full_last", 32'(dout), 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("both_full_drained", 32'(empty), 32'd1);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("both_empty_count", 32'(count), 32'd1);
        checkOutput("both_empty_dout", 32'(dout), 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Clear request loses to a dropping write in the same cycle
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        checkOutput("race_overflow", 32'(overflow), 32'd1);
        checkOutput("race_count", 32'(count), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Pointer wrap through 40 write/read pairs
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            checkOutput("wrap_dout", 32'(dout), 32'(8'(8'h60 + i)));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("wrap_count", 32'(count), 32'd0);

        // Randomized traffic with shifting write pressure
        wr_bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) wr_bias = $urandom_range(25, 85);
            applyStimulus($urandom_range(0, 99) < wr_bias,
                          8'($urandom),
                          $urandom_range(0, 99) < (110 - wr_bias),
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 149) == 0);
        end

        // Reset in the middle of traffic, competing with every other input
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        checkOutput("midrst_full", 32'(full), 32'd0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 8, giving the byte width stored per entry.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, giving depth 2**ADDR_WIDTH (16 entries).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The module SHALL have port wr, input, 1, write strobe, driven directly by the receiver's rx_done pulse.
REQ-006 The module SHALL have port din, input, DATA_SIZE, write data, driven by the receiver's dout.
REQ-007 The module SHALL have port rd, input, 1, read/pop strobe from the consumer.
REQ-008 The module SHALL have port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-009 The module SHALL have port dout, output, DATA_SIZE, oldest stored byte (show-ahead).
REQ-010 The module SHALL have port empty, output, 1, high when count == 0.
REQ-011 The module SHALL have port full, output, 1, high when count == 2**ADDR_WIDTH.
REQ-012 The module SHALL have port count, output, ADDR_WIDTH+1, number of stored entries.
REQ-013 The module SHALL have port overflow, output, 1, sticky flag: a write was dropped.

Function
REQ-014 The module SHALL store din at the write pointer and increment it on a clk edge with wr=1 and full=0.
REQ-015 The module SHALL increment the read pointer on a clk edge with rd=1 and empty=0.
REQ-016 The module SHALL present mem[read pointer] on dout combinationally, so dout is valid whenever empty=0 with zero read latency; dout is don't-care when empty=1.
REQ-017 The module SHALL make a written byte visible on dout/empty on the cycle after the write edge.
REQ-018 The module SHALL wrap both ADDR_WIDTH-bit pointers from 2**ADDR_WIDTH-1 to 0 with no gap.
REQ-019 The module SHALL, on wr=1 and rd=1 with 0 < count < max, perform both operations; count unchanged.
REQ-020 The module SHALL, on wr=1 and rd=1 with empty=1, perform the write only and ignore the read; count becomes 1.
REQ-021 The module SHALL, on wr=1 and rd=1 with full=1, perform both operations (the read frees the slot); count stays max; overflow is not set.
REQ-022 The module SHALL, on wr=1, rd=0 and full=1, drop din, leave memory and pointers unchanged, and set overflow on the next edge.
REQ-023 The module SHALL ignore rd=1 when empty=1 with no state change (no underflow flag).
REQ-024 The module SHALL clear overflow on a clk edge with clr_ovf=1; if a dropping write occurs in the same cycle, set takes priority and overflow stays 1.
REQ-025 The module SHALL derive full and empty from a registered count of width ADDR_WIDTH+1, updated +1, -1 or 0 per cycle.

Reset
REQ-026 The module SHALL, on a clk edge with rst=1, set both pointers to 0, count to 0, and overflow to 0, so that empty=1 and full=0.
REQ-027 The module SHALL give rst priority over wr, rd and clr_ovf in the same cycle; a mid-operation reset discards all stored bytes.
REQ-028 The module SHALL NOT clear memory contents on reset.

Structure
REQ-029 The module SHALL take DATA_SIZE and ADDR_WIDTH defaults from a shared UART include/package that also holds the receiver's data_size, so the FIFO and receiver widths match.
REQ-030 The module SHALL be a single module with an inline register-file array and no sub-modules; the pointer/count control is one registered block plus next-state logic.

Verification
REQ-031 The bench SHALL check reset: assert rst for 2 cycles mid-traffic -> empty=1, full=0, count=0, overflow=0 on the next cycle.
REQ-032 The bench SHALL check ordering: write 0x41, 0x42, 0x43 with single-cycle wr pulses -> dout=0x41 with count=3; each rd pulse then yields 0x42, 0x43, and empty=1 after the third rd.
REQ-033 The bench SHALL check fill and overflow: write 0x00..0x0F -> full=1, count=16; a further write of 0xAA -> overflow=1, count=16, and 16 reads return 0x00..0x0F (0xAA absent).
REQ-034 The bench SHALL check simultaneous access: with full=1, pulse wr=1 (0x55) and rd=1 together -> count=16, overflow=0, and 0x55 read out last. With empty=1, pulse wr and rd together -> count=1, dout=0x55.
REQ-035 The bench SHALL check pointer wrap: perform 40 write/read pairs of incrementing data -> every read matches and count returns to 0.
REQ-036 The bench SHALL check the overflow clear race: with overflow=1, hold clr_ovf=1 -> overflow=0 next cycle; with full=1, drive clr_ovf=1 together with wr=1 -> overflow remains 1.
